// File: rtl/rv_isa_pkg.sv
// RV32 base opcode constants and the shared types used by the issue scoreboard.
package rv_isa_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic wr_rd;
  } operand_use_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sb_state_t;

endpackage

// File: rtl/operand_use_decode.sv
// Combinational opcode classifier: which of rs1/rs2/rd an instruction actually uses.
module operand_use_decode
  import rv_isa_pkg::*;
(
  input  logic [6:0]   opcode,
  output operand_use_t operand_use
);

  // Opcode class to live operand fields; unknown opcodes touch nothing
  always_comb begin
    operand_use = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_rd: 1'b0};
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL:
        operand_use = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_rd: 1'b1};
      OPC_JALR, OPC_LOAD, OPC_OPIMM:
        operand_use = '{use_rs1: 1'b1, use_rs2: 1'b0, wr_rd: 1'b1};
      OPC_BRANCH, OPC_STORE:
        operand_use = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_rd: 1'b0};
      OPC_OP:
        operand_use = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_rd: 1'b1};
      default:
        operand_use = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_rd: 1'b0};
    endcase
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: stalls decode on RAW/WAW/occupancy hazards, with flush and drain control.
// Optional feature macro ISSUE_SCOREBOARD_WB_BYPASS_EN: a same-cycle writeback releases the hazard.
module issue_scoreboard
  import rv_isa_pkg::*;
#(
  parameter  int NREG         = 32,
  parameter  int MAX_INFLIGHT = 4,
  localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  input  logic [6:0]      dec_opcode,
  input  logic [4:0]      dec_rd,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  output logic            issue_ready,
  output logic            issue_fire,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  input  logic            drain_req,
  output logic            drain_done,
  output logic [NREG-1:0] busy_mask,
  output logic [CW-1:0]   inflight_cnt,
  output logic            err_spurious
);

  localparam logic [NREG-1:0] BIT0    = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [NREG-1:0] NONE    = {NREG{1'b0}};
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_INFLIGHT);

  operand_use_t    use_s;
  logic            rs1_live_s, rs2_live_s, wr_live_s;
  logic            wb_hit_s, wb_release_s, hazard_s, ready_s, set_s;
  logic [NREG-1:0] wb_onehot_s, rd_onehot_s, eff_busy_s, busy_nxt_s;
  logic [NREG-1:0] busy_r;
  logic [CW-1:0]   cnt_avail_s, cnt_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic            err_r, done_r, done_nxt_s;
  sb_state_t       state_r, state_nxt_s;

  operand_use_decode u_decode (
    .opcode      (dec_opcode),
    .operand_use (use_s)
  );

  // x0 is never a hazard source or a tracked destination
  assign rs1_live_s   = use_s.use_rs1 & (dec_rs1 != 5'd0);
  assign rs2_live_s   = use_s.use_rs2 & (dec_rs2 != 5'd0);
  assign wr_live_s    = use_s.wr_rd & (dec_rd != 5'd0);
  assign wb_hit_s     = wb_valid & (wb_rd != 5'd0);
  assign wb_onehot_s  = BIT0 << wb_rd;
  assign rd_onehot_s  = BIT0 << dec_rd;
  assign wb_release_s = wb_hit_s & busy_r[wb_rd];

`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
  assign eff_busy_s  = busy_r & ~(wb_hit_s ? wb_onehot_s : NONE);
  assign cnt_avail_s = cnt_r - (wb_release_s ? CW'(1) : CW'(0));
`else
  assign eff_busy_s  = busy_r;
  assign cnt_avail_s = cnt_r;
`endif

  assign hazard_s = (rs1_live_s & eff_busy_s[dec_rs1])
                  | (rs2_live_s & eff_busy_s[dec_rs2])
                  | (wr_live_s  & eff_busy_s[dec_rd])
                  | (wr_live_s  & (cnt_avail_s == CNT_MAX));
  assign ready_s  = ~hazard_s & ~flush & (state_r == RUN) & ~drain_req;
  assign set_s    = dec_valid & ready_s & wr_live_s;

  // Next busy mask and count: flush dominates; an issue to the register being written back keeps it busy
  always_comb begin
    busy_nxt_s = busy_r;
    cnt_nxt_s  = cnt_r;
    if (flush) begin
      busy_nxt_s = NONE;
      cnt_nxt_s  = CW'(0);
    end else begin
      busy_nxt_s = (busy_r & ~(wb_release_s ? wb_onehot_s : NONE))
                 | (set_s ? rd_onehot_s : NONE);
      cnt_nxt_s  = cnt_r + (set_s ? CW'(1) : CW'(0)) - (wb_release_s ? CW'(1) : CW'(0));
    end
  end

  // Drain sequencing: leave DRAIN once nothing is outstanding and pulse drain_done
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (drain_req) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (cnt_r == CW'(0)) begin
          state_nxt_s = RUN;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = RUN;
        done_nxt_s  = 1'b0;
      end
    endcase
  end

  // State registers; the spurious-writeback flag is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r  <= NONE;
      cnt_r   <= CW'(0);
      err_r   <= 1'b0;
      done_r  <= 1'b0;
      state_r <= RUN;
    end else begin
      busy_r  <= busy_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_r | (wb_hit_s & ~busy_r[wb_rd] & ~flush);
      done_r  <= done_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign issue_ready  = ready_s;
  assign issue_fire   = dec_valid & ready_s;
  assign busy_mask    = busy_r;
  assign inflight_cnt = cnt_r;
  assign err_spurious = err_r;
  assign drain_done   = done_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios then a random stream vs a reference model.
// Honours ISSUE_SCOREBOARD_WB_BYPASS_EN when the design is built with it.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        issue_ready, issue_fire;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush, drain_req, drain_done;
  logic [31:0] busy_mask;
  logic [2:0]  inflight_cnt;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit pend [32];
  bit m_err, m_drain, m_done, last_fire;

  localparam logic [6:0] LUI = 7'b0110111, OP = 7'b0110011, LOAD = 7'b0000011, STORE = 7'b0100011;
  logic [6:0] opc_tab [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                               7'b0010011, 7'b1100011, 7'b0100011, 7'b0110011, 7'b1110011};

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .issue_ready(issue_ready), .issue_fire(issue_fire),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .drain_req(drain_req),
    .drain_done(drain_done), .busy_mask(busy_mask), .inflight_cnt(inflight_cnt),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {rs1 used, rs2 used, writes rd}
  function automatic logic [2:0] uses_of(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: return 3'b001;
      7'b1100111, 7'b0000011, 7'b0010011: return 3'b101;
      7'b1100011, 7'b0100011:             return 3'b110;
      7'b0110011:                         return 3'b111;
      default:                            return 3'b000;
    endcase
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(pend[i]);
    return n;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = pend[i];
    return v;
  endfunction

  function automatic bit m_eff(input int r);
    if (r == 0) return 1'b0;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    if (wb_valid && int'(wb_rd) == r) return 1'b0;
`endif
    return pend[r];
  endfunction

  function automatic bit m_ready();
    logic [2:0] u;
    bit haz;
    int c;
    u = uses_of(dec_opcode);
    haz = (u[2] && m_eff(int'(dec_rs1))) || (u[1] && m_eff(int'(dec_rs2))) || (u[0] && m_eff(int'(dec_rd)));
    c = m_cnt();
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    if (wb_valid && wb_rd != 5'd0 && pend[wb_rd]) c--;
`endif
    if (u[0] && dec_rd != 5'd0 && c == 4) haz = 1'b1;
    return !haz && !flush && !m_drain && !drain_req;
  endfunction

  task automatic model_next(input bit fire);
    int c0;
    c0 = m_cnt();
    m_done = m_drain && c0 == 0;
    m_drain = m_drain ? (c0 != 0) : drain_req;
    if (flush) begin
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    end else begin
      if (wb_valid && wb_rd != 5'd0) begin
        if (pend[wb_rd]) pend[wb_rd] = 1'b0;
        else m_err = 1'b1;
      end
      if (fire && uses_of(dec_opcode)[0] && dec_rd != 5'd0) pend[dec_rd] = 1'b1;
    end
  endtask

  // one clock: combinational checks before the edge, registered checks after it
  task automatic cycle();
    bit exp_rdy;
    #1;
    exp_rdy = m_ready();
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, exp_rdy});
    chk("issue_fire", {31'd0, issue_fire}, {31'd0, dec_valid && exp_rdy});
    last_fire = dec_valid && exp_rdy;
    model_next(last_fire);
    @(posedge clk);
    #1;
    chk("busy_mask", busy_mask, m_mask());
    chk("inflight_cnt", {29'd0, inflight_cnt}, m_cnt());
    chk("err_spurious", {31'd0, err_spurious}, {31'd0, m_err});
    chk("drain_done", {31'd0, drain_done}, {31'd0, m_done});
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input bit exp);
    #1;
    chk(tag, {31'd0, issue_ready}, {31'd0, exp});
  endtask

  task automatic set_dec(input bit v, input logic [6:0] op, input int rd, input int rs1, input int rs2);
    dec_valid = v; dec_opcode = op;
    dec_rd = 5'(rd); dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2);
  endtask

  task automatic set_wb(input bit v, input int r);
    wb_valid = v; wb_rd = 5'(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_dec(1'b0, 7'd0, 0, 0, 0); set_wb(1'b0, 0);
    flush = 1'b0; drain_req = 1'b0;
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    m_err = 1'b0; m_drain = 1'b0; m_done = 1'b0; last_fire = 1'b0;
    #1;
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_cnt", {29'd0, inflight_cnt}, 32'd0);
    chk("rst_err", {31'd0, err_spurious}, 32'd0);
    chk("rst_done", {31'd0, drain_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: RAW on x5 released by its writeback
    set_dec(1'b1, LOAD, 5, 0, 0); cycle();
    set_dec(1'b1, OP, 6, 5, 0);
    peek("t1_stall_a", 1'b0); cycle();
    peek("t1_stall_b", 1'b0); cycle();
    set_wb(1'b1, 5);
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    peek("t1_wb_cycle", 1'b1); cycle();
    set_dec(1'b0, 7'd0, 0, 0, 0); set_wb(1'b0, 0); cycle();
`else
    peek("t1_wb_cycle", 1'b0); cycle();
    set_wb(1'b0, 0);
    peek("t1_after_wb", 1'b1); cycle();
    set_dec(1'b0, 7'd0, 0, 0, 0); cycle();
`endif
    set_wb(1'b1, 6); cycle(); set_wb(1'b0, 0);

    // 2: occupancy limit blocks writes but not a store
    for (int r = 1; r <= 4; r++) begin
      set_dec(1'b1, LUI, r, 0, 0); cycle();
    end
    chk("t2_cnt_full", {29'd0, inflight_cnt}, 32'd4);
    set_dec(1'b1, LUI, 6, 0, 0);
    peek("t2_fifth_stalls", 1'b0); cycle();
    set_dec(1'b1, STORE, 0, 7, 8);
    peek("t2_store_issues", 1'b1); cycle();
    set_dec(1'b0, 7'd0, 0, 0, 0);
    for (int r = 1; r <= 4; r++) begin
      set_wb(1'b1, r); cycle();
    end
    set_wb(1'b0, 0);

    // 3: writes to x0 are not tracked
    set_dec(1'b1, LUI, 0, 0, 0); peek("t3_lui_x0", 1'b1); cycle();
    set_dec(1'b1, OP, 0, 0, 0);  peek("t3_op_x0", 1'b1); cycle();
    chk("t3_busy", busy_mask, 32'd0);
    chk("t3_cnt", {29'd0, inflight_cnt}, 32'd0);
    set_dec(1'b0, 7'd0, 0, 0, 0);

    // 4: flush swallows a same-cycle writeback; later writeback is spurious
    set_dec(1'b1, LUI, 3, 0, 0); cycle();
    set_dec(1'b1, LUI, 9, 0, 0); cycle();
    set_dec(1'b1, LUI, 12, 0, 0);
    flush = 1'b1; set_wb(1'b1, 3);
    peek("t4_flush_blocks", 1'b0); cycle();
    flush = 1'b0; set_dec(1'b0, 7'd0, 0, 0, 0); set_wb(1'b0, 0);
    chk("t4_busy", busy_mask, 32'd0);
    chk("t4_cnt", {29'd0, inflight_cnt}, 32'd0);
    chk("t4_err_clear", {31'd0, err_spurious}, 32'd0);
    set_wb(1'b1, 9); cycle(); set_wb(1'b0, 0);
    chk("t4_err_set", {31'd0, err_spurious}, 32'd1);

    // reset mid-operation discards pending writes
    do_reset();
    set_dec(1'b1, LUI, 10, 0, 0); cycle();
    do_reset();
    set_wb(1'b1, 10); cycle(); set_wb(1'b0, 0);
    chk("rst_mid_err", {31'd0, err_spurious}, 32'd1);
    do_reset();

    // 5: drain holds issue until both writes complete
    set_dec(1'b1, LUI, 1, 0, 0); cycle();
    set_dec(1'b1, LUI, 2, 0, 0); cycle();
    set_dec(1'b1, LUI, 3, 0, 0);
    drain_req = 1'b1;
    peek("t5_req_blocks", 1'b0); cycle();
    peek("t5_drain_blocks", 1'b0); cycle();
    set_wb(1'b1, 1); cycle();
    set_wb(1'b1, 2); cycle();
    set_wb(1'b0, 0); drain_req = 1'b0;
    chk("t5_no_early_done", {31'd0, drain_done}, 32'd0);
    cycle();
    chk("t5_done_pulse", {31'd0, drain_done}, 32'd1);
    peek("t5_run_again", 1'b1); cycle();
    chk("t5_done_once", {31'd0, drain_done}, 32'd0);
    set_dec(1'b0, 7'd0, 0, 0, 0);
    set_wb(1'b1, 3); cycle(); set_wb(1'b0, 0);

    // 6: random stream against the model
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if (!dec_valid || last_fire) begin
        if ($urandom_range(0, 9) < 7)
          set_dec(1'b1, opc_tab[$urandom_range(0, 9)], int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        else
          set_dec(1'b0, 7'd0, 0, 0, 0);
      end
      set_wb(1'b0, 0);
      if ($urandom_range(0, 99) < 40) begin
        int r;
        r = int'($urandom_range(1, 7));
        if (pend[r] || $urandom_range(0, 199) == 0) set_wb(1'b1, r);
      end
      flush = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) drain_req = ~drain_req;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
